icache_assoc: RTL
=================

Name: icache_assoc

Overview:
- Parametrised set-associative instruction cache for the fetch path, between the Instruction Unit and the memory controller.
- Lookup is combinational, with the hit or miss answer in the same cycle, so the Instruction Unit fetch interface is unchanged.
- Unlike the direct-mapped predecessor, it owns its miss handling: a refill FSM issues block requests with a valid/ready handshake, picks a victim way per set, and supports whole-cache flush.

Parameters:
- BLOCK_WIDTH, 4: log2 of block size in bytes; must be >= 2; words per block WPB = 2^(BLOCK_WIDTH-2).
- SET_WIDTH, 6: log2 of set count; SETS = 2^SET_WIDTH.
- WAYS, 2: associativity; power of two, 1..8.
- TAG_W, derived as 32-SET_WIDTH-BLOCK_WIDTH: tag width.

Ports:
- clkIn  in  1  system clock
- resetIn  in  1  asynchronous, active-low reset
- flushIn  in  1  invalidate all lines (e.g. fence.i)
- instrInValid  in  1  fetch request valid
- instrAddrIn  in  32  fetch byte address; bits [1:0] ignored
- instrOutValid  out  1  hit: instrOut is valid this cycle
- instrOut  out  32  instruction word
- memReqValid  out  1  block refill request
- memReqAddr  out  32-BLOCK_WIDTH  block address of the refill
- memReqReady  in  1  memory controller accepts the request
- memDataValid  in  1  refill data valid, exactly one pulse per accepted request
- memDataIn  in  2^BLOCK_WIDTH*8  refill block; word 0 in the LSBs
- busy  out  1  FSM not IDLE

Behaviour:
- Address split: offset = [BLOCK_WIDTH-1:2], index = [BLOCK_WIDTH+SET_WIDTH-1:BLOCK_WIDTH], tag = [31:BLOCK_WIDTH+SET_WIDTH].
- Hit: instrInValid, any way valid, and stored tag equal to the address tag. Comparison is parallel across all ways; at most one way can match.
- On a hit, instrOutValid=1 and instrOut is that way's word at the offset, combinational in the same cycle.
- On a non-hit, instrOutValid=0. instrOut is don't-care, but it is driven to 0 when instrOutValid=0 so traces stay deterministic.
- Hits are served in every FSM state, including during a refill to a different block.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ: instrInValid and miss and not flushIn. Latch the block address into missAddr.
  - REQ: memReqValid=1 and memReqAddr=missAddr, held stable until memReqReady; then go to WAIT.
  - WAIT -> IDLE: on memDataValid, write the block into the victim way of set missAddr index. Set valid, write the tag, update the replacement state.
- Fill-to-hit latency: a re-presented address hits in the cycle after memDataValid. There is no same-cycle bypass of memDataIn.
- A fetch address change while in REQ or WAIT does not cancel the refill. The original block is always filled.
- Victim selection, fixed at REQ->WAIT:
  - Lowest-numbered invalid way if any way is invalid.
  - Otherwise a per-set round-robin pointer (log2 WAYS bits), which advances by 1 on each fill of that set and wraps at WAYS.
  - With WAYS=1 the victim is always way 0.
- Hits do not change the replacement state.
- memDataValid in IDLE or REQ is ignored (protocol violation; asserted in simulation).
- Flush behaviour:
  - Flush in IDLE: all valid bits clear next cycle, round-robin pointers reset to 0, and no request is launched that cycle.
  - Flush in REQ: the request stays pending until accepted; its data is discarded in WAIT and the valid bit is not set.
  - Flush in WAIT: the returning data is likewise discarded and the valid bit is not set.
  - Flush during WAIT arms a discard flag, which is cleared on the next return to IDLE.
  - Flush and memDataValid in the same cycle: the flush wins and the fill is discarded.
- Reset values (resetIn low, asynchronous): state=IDLE, all valid bits 0, round-robin pointers 0, discard flag 0, memReqValid=0, busy=0, instrOutValid=0. Tag and data arrays are not reset.
- Reset mid-refill abandons the transaction. The memory controller is reset by the same signal.

Optional Feature:
- ICACHE_PERF_EN defined adds two output ports, hitCount[31:0] and missCount[31:0].
  - hitCount increments on each cycle where instrInValid and hit.
  - missCount increments on each IDLE->REQ transition.
  - Both clear on reset, wrap at 2^32, and are unaffected by flush.
- Undefined: the ports and counters are absent, with no other behavioural difference.

Decomposition:
- Shared package icache_pkg holds:
  - the FSM state enum (IDLE/REQ/WAIT);
  - address-field width helpers: offset, index and tag widths derived from BLOCK_WIDTH and SET_WIDTH.
- One natural sub-module, icache_way: one way's valid bits, tag array and data array, with a write port and a tag-compare/word-read port. It is instantiated WAYS times by generate.
- Victim selection and the FSM stay in the top level.

Test Plan:
- Cold miss, defaults: fetch 0x0000_1004.
  - Expect: instrOutValid=0; memReqValid with memReqAddr=0x100 until memReqReady.
  - Return the block {W3,W2,W1,W0}; the next cycle instrOutValid=1 and instrOut=W1.
- Associativity: fill 0x0000_1000 then 0x0000_2000, both index 0.
  - Expect: both hit afterwards; a third block, 0x0000_3000, evicts way 0 (the 0x1000 block, round-robin), and 0x2000 still hits.
- Hit under refill: with 0x1000 resident, start a miss on 0x4000 and hold memReqReady=0 for 5 cycles.
  - Expect: fetches of 0x1008 hit every cycle meanwhile; memReqAddr stays stable.
- Flush: assert flushIn during WAIT of a refill to 0x5000, then return the data.
  - Expect: no line valid afterwards; a fetch of 0x5000 misses again.
- Async reset: drop resetIn mid-REQ, between clock edges.
  - Expect: memReqValid and busy fall immediately; after release, a previously resident address misses.
- With ICACHE_PERF_EN: sequence of 3 misses then 10 hits.
  - Expect: missCount=3, hitCount=10; a flush leaves both unchanged.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // A 4-byte block has no offset field; keep a 1-bit vector tied to zero instead.
    function automatic int off_w(input int block_width);
        return (block_width > 2) ? block_width - 2 : 1;
    endfunction

    function automatic int idx_w(input int set_width);
        return (set_width > 0) ? set_width : 1;
    endfunction

    function automatic int tag_w(input int block_width, input int set_width);
        return 32 - set_width - block_width;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bits (async reset), tag and data arrays (no reset),
// one write port and a combinational tag-compare/word-read port.
module icache_way #(
    parameter int SETS  = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 22,
    parameter int OFF_W = 2,
    parameter int WPB   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [IDX_W-1:0]       wr_idx_i,
    input  logic [TAG_W-1:0]       wr_tag_i,
    input  logic [WPB-1:0][31:0]   wr_data_i,
    input  logic                   rd_en_i,
    input  logic [IDX_W-1:0]       rd_idx_i,
    input  logic [TAG_W-1:0]       rd_tag_i,
    input  logic [OFF_W-1:0]       rd_off_i,
    output logic                   hit_o,
    output logic [31:0]            word_o,
    input  logic [IDX_W-1:0]       vq_idx_i,
    output logic                   vq_vld_o
);

    logic [SETS-1:0]     valid_q;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [WPB-1:0][31:0] data_q [SETS];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign hit_o    = rd_en_i && valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign word_o   = hit_o ? data_q[rd_idx_i][rd_off_i] : 32'h0;
    assign vq_vld_o = valid_q[vq_idx_i];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with same-cycle hit and an IDLE/REQ/WAIT refill FSM.
// Define ICACHE_PERF_EN to add the hitCount/missCount performance counter ports.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int BLOCK_WIDTH = 4,
    parameter int SET_WIDTH   = 6,
    parameter int WAYS        = 2
) (
    input  logic                          clkIn,
    input  logic                          resetIn,
    input  logic                          flushIn,
    input  logic                          instrInValid,
    input  logic [31:0]                   instrAddrIn,
    output logic                          instrOutValid,
    output logic [31:0]                   instrOut,
    output logic                          memReqValid,
    output logic [31-BLOCK_WIDTH:0]       memReqAddr,
    input  logic                          memReqReady,
    input  logic                          memDataValid,
    input  logic [(2**BLOCK_WIDTH)*8-1:0] memDataIn,
    output logic                          busy
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]                   hitCount,
    output logic [31:0]                   missCount
`endif
);

    localparam int TAG_W = tag_w(BLOCK_WIDTH, SET_WIDTH);
    localparam int OFF_W = off_w(BLOCK_WIDTH);
    localparam int IDX_W = idx_w(SET_WIDTH);
    localparam int WPB   = 1 << (BLOCK_WIDTH - 2);
    localparam int SETS  = 1 << SET_WIDTH;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BA_W  = 32 - BLOCK_WIDTH;

    state_e              state_q;
    logic [BA_W-1:0]     miss_q;
    logic [WAY_W-1:0]    victim_q;
    logic                discard_q;
    logic [WAY_W-1:0]    rr_q [SETS];

    logic [OFF_W-1:0]    f_off;
    logic [IDX_W-1:0]    f_idx;
    logic [TAG_W-1:0]    f_tag;
    logic [IDX_W-1:0]    m_idx;
    logic [TAG_W-1:0]    m_tag;
    logic [WAYS-1:0]     way_hit;
    logic [WAYS-1:0]     way_vld;
    logic [WAYS-1:0]     way_we;
    logic [31:0]         way_word [WAYS];
    logic [WAY_W-1:0]    victim;
    logic [WAY_W-1:0]    rr_next;
    logic                start_miss;
    logic                fill;
    logic                unused_addr_lsb;

    if (BLOCK_WIDTH > 2) begin : g_off
        assign f_off = instrAddrIn[BLOCK_WIDTH-1:2];
    end else begin : g_no_off
        assign f_off = '0;
    end

    assign f_idx           = IDX_W'(instrAddrIn >> BLOCK_WIDTH);
    assign f_tag           = instrAddrIn[31 -: TAG_W];
    assign m_idx           = IDX_W'(miss_q);
    assign m_tag           = miss_q[BA_W-1 -: TAG_W];
    assign unused_addr_lsb = ^instrAddrIn[1:0];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_we[w] = fill && (victim_q == WAY_W'(w));

        icache_way #(
            .SETS  (SETS),
            .IDX_W (IDX_W),
            .TAG_W (TAG_W),
            .OFF_W (OFF_W),
            .WPB   (WPB)
        ) u_way (
            .clk_i     (clkIn),
            .rst_n_i   (resetIn),
            .flush_i   (flushIn),
            .wr_en_i   (way_we[w]),
            .wr_idx_i  (m_idx),
            .wr_tag_i  (m_tag),
            .wr_data_i (memDataIn),
            .rd_en_i   (instrInValid),
            .rd_idx_i  (f_idx),
            .rd_tag_i  (f_tag),
            .rd_off_i  (f_off),
            .hit_o     (way_hit[w]),
            .word_o    (way_word[w]),
            .vq_idx_i  (m_idx),
            .vq_vld_o  (way_vld[w])
        );
    end

    // Each way zeroes its word unless it hits, so an OR gives the hit word or 0.
    always_comb begin
        instrOut = '0;
        for (int w = 0; w < WAYS; w++) begin
            instrOut = instrOut | way_word[w];
        end
    end

    assign instrOutValid = |way_hit;

    always_comb begin
        victim = rr_q[m_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_vld[w]) victim = WAY_W'(w);
        end
    end

    assign rr_next    = (WAYS == 1) ? '0 : rr_q[m_idx] + 1'b1;
    assign start_miss = (state_q == IDLE) && instrInValid && !instrOutValid && !flushIn;
    assign fill       = (state_q == WAIT) && memDataValid && !discard_q && !flushIn;

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state_q   <= IDLE;
            miss_q    <= '0;
            victim_q  <= '0;
            discard_q <= 1'b0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            if (flushIn) begin
                for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (start_miss) begin
                        state_q <= REQ;
                        miss_q  <= instrAddrIn[31:BLOCK_WIDTH];
                    end
                end
                REQ: begin
                    if (flushIn) discard_q <= 1'b1;
                    if (memReqReady) begin
                        state_q  <= WAIT;
                        victim_q <= victim;
                    end
                end
                WAIT: begin
                    if (flushIn) discard_q <= 1'b1;
                    if (memDataValid) begin
                        state_q   <= IDLE;
                        discard_q <= 1'b0;
                        if (fill) rr_q[m_idx] <= rr_next;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign memReqValid = (state_q == REQ);
    assign memReqAddr  = miss_q;
    assign busy        = (state_q != IDLE);

    a_data_only_in_wait: assert property (@(posedge clkIn) disable iff (!resetIn)
        memDataValid |-> (state_q == WAIT));

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (instrOutValid) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (start_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hitCount  = hit_cnt_q;
    assign missCount = miss_cnt_q;
`endif

endmodule
